// File: rtl/frame_dark_detect_pkg.sv
// Shared constants for the frame brightness detector and the downstream sync delay.
package frame_dark_detect_pkg;

   localparam int LAT    = 3;
   localparam int COEF_W = 8;
   localparam int COEF_R = 77;
   localparam int COEF_G = 150;
   localparam int COEF_B = 29;

   typedef struct packed {
      logic vs;
      logic de;
   } sync_t;

endpackage

// File: rtl/frame_dark_detect_shift_reg.sv
// Clock-enabled delay line of DELAYS stages, synchronous active-high clear.
module shift_reg #(
   parameter int DELAYS = 3,
   parameter int WIDTH  = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cen_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage [DELAYS];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DELAYS; i++) stage[i] <= '0;
      end else if (cen_i) begin
         stage[0] <= d_i;
         for (int i = 1; i < DELAYS; i++) stage[i] <= stage[i-1];
      end
   end

   assign q_o = stage[DELAYS-1];

endmodule

// File: rtl/frame_dark_detect.sv
// Luma pipeline with per-frame bright-pixel count; dark_o asks downstream to
// invert the next frame when the last completed frame was predominantly bright.
module frame_dark_detect
   import frame_dark_detect_pkg::*;
#(
   parameter int WIDTH_C    = 8,
   parameter int THRES_LUMA = 128,
   parameter int THRES_CNT  = 1036800,
   parameter int CNT_W      = 22,
   parameter bit VS_POL     = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cen_i,
   input  logic                 de_i,
   input  logic                 vs_i,
   input  logic [3*WIDTH_C-1:0] rgb_i,
   output logic [WIDTH_C-1:0]   luma_o,
   output logic                 bright_o,
   output logic                 dark_o,
   output logic [CNT_W-1:0]     cnt_o,
   output logic                 upd_o
);

   localparam int               PW      = WIDTH_C + COEF_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [31:0]      THR_L   = 32'(THRES_LUMA);
   localparam logic [31:0]      THR_C   = 32'(THRES_CNT);

   logic [WIDTH_C-1:0] r, g, b;
   logic [PW-1:0]      pr, pg, pb, sum;
   sync_t              sync_in, sync_d;
   logic               vs_act, vs_act_q, boundary;
   logic               armed, upd_q;
   logic [CNT_W-1:0]   counter;

   assign {r, g, b} = rgb_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pr     <= '0;
         pg     <= '0;
         pb     <= '0;
         sum    <= '0;
         luma_o <= '0;
      end else if (cen_i) begin
         pr     <= PW'(r) * PW'(COEF_R);
         pg     <= PW'(g) * PW'(COEF_G);
         pb     <= PW'(b) * PW'(COEF_B);
         sum    <= pr + pg + pb;
         luma_o <= sum[PW-1 -: WIDTH_C];
      end
   end

   // de/vs travel alongside the pixel so the count logic sees aligned copies
   assign sync_in = '{vs: vs_i, de: de_i};

   shift_reg #(
      .DELAYS (LAT),
      .WIDTH  ($bits(sync_t))
   ) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .cen_i (cen_i),
      .d_i   (sync_in),
      .q_o   (sync_d)
   );

   assign bright_o = sync_d.de & (32'(luma_o) >= THR_L);
   assign vs_act   = (sync_d.vs == VS_POL);
   assign boundary = vs_act & ~vs_act_q;

   // A pixel on the boundary cycle seeds the new frame's count.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vs_act_q <= 1'b0;
         armed    <= 1'b0;
         counter  <= '0;
         cnt_o    <= '0;
         dark_o   <= 1'b0;
         upd_q    <= 1'b0;
      end else if (cen_i) begin
         vs_act_q <= vs_act;
         upd_q    <= 1'b0;
         if (boundary) begin
            counter <= CNT_W'(bright_o);
            armed   <= 1'b1;
            if (armed) begin
               cnt_o  <= counter;
               dark_o <= (32'(counter) > THR_C);
               upd_q  <= 1'b1;
            end
         end else if (bright_o && (counter != CNT_MAX)) begin
            counter <= counter + CNT_W'(1);
         end
      end
   end

   assign upd_o = upd_q & cen_i;

endmodule

// File: tb/tb_frame_dark_detect.sv
// Self-checking bench: randomized and directed stimulus against a queue-based frame model.
module tb_frame_dark_detect;

   logic        clk = 1'b0;
   logic        rst, cen, de, vs;
   logic [23:0] rgb;
   logic [7:0]  luma_o;
   logic        bright_o, dark_o, upd_o;
   logic [2:0]  cnt_o;

   int tests    = 0;
   int fails    = 0;
   int upd_seen = 0;

   always #5 clk = ~clk;

   frame_dark_detect #(
      .WIDTH_C    (8),
      .THRES_LUMA (128),
      .THRES_CNT  (3),
      .CNT_W      (3),
      .VS_POL     (1'b1)
   ) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .cen_i    (cen),
      .de_i     (de),
      .vs_i     (vs),
      .rgb_i    (rgb),
      .luma_o   (luma_o),
      .bright_o (bright_o),
      .dark_o   (dark_o),
      .cnt_o    (cnt_o),
      .upd_o    (upd_o)
   );

   typedef struct {
      bit de;
      bit vs;
      int r;
      int g;
      int b;
   } pix_t;

   // q[0] is the pixel currently presented at the outputs
   pix_t q[$];
   bit   m_armed, m_prev, m_dark, m_upd;
   int   m_count, m_cnt;

   function automatic int luma_of(pix_t p);
      return (p.r * 77 + p.g * 150 + p.b * 29) / 256;
   endfunction

   function automatic bit bright_of(pix_t p);
      return p.de && (luma_of(p) >= 128);
   endfunction

   task automatic model_reset();
      pix_t z;
      z = '{de: 1'b0, vs: 1'b0, r: 0, g: 0, b: 0};
      q.delete();
      for (int i = 0; i < 3; i++) q.push_back(z);
      m_armed = 0; m_prev = 0; m_dark = 0; m_upd = 0;
      m_count = 0; m_cnt = 0;
   endtask

   task automatic model_step();
      pix_t e, cur;
      bit   bnd;
      if (rst) begin
         model_reset();
      end else if (cen) begin
         e   = q[0];
         bnd = e.vs && !m_prev;
         m_upd = 0;
         if (bnd) begin
            if (m_armed) begin
               m_cnt  = (m_count > 7) ? 7 : m_count;
               m_dark = (m_cnt > 3);
               m_upd  = 1;
            end
            m_armed = 1;
            m_count = bright_of(e) ? 1 : 0;
         end else begin
            m_count += bright_of(e) ? 1 : 0;
         end
         m_prev = e.vs;
         cur = '{de: de, vs: vs, r: int'(rgb[23:16]), g: int'(rgb[15:8]), b: int'(rgb[7:0])};
         void'(q.pop_front());
         q.push_back(cur);
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("luma",   int'(luma_o),   luma_of(q[0]));
      chk("bright", int'(bright_o), int'(bright_of(q[0])));
      chk("dark",   int'(dark_o),   int'(m_dark));
      chk("cnt",    int'(cnt_o),    m_cnt);
      chk("upd",    int'(upd_o),    int'(m_upd && cen));
      if (upd_o) upd_seen++;
   endtask

   task automatic tick(input logic r_in, input logic c_in, input logic d_in,
                       input logic v_in, input logic [23:0] p_in);
      rst = r_in; cen = c_in; de = d_in; vs = v_in; rgb = p_in;
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic send_frame(input int nb, input bit vs_bright);
      tick(1'b0, 1'b1, vs_bright, 1'b1, vs_bright ? 24'hFFFFFF : 24'h000000);
      for (int i = 0; i < nb; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 24'hFFFFFF);
      for (int i = 0; i < 3; i++)  tick(1'b0, 1'b1, 1'b1, 1'b0, 24'h101010);
   endtask

   // enabled cycle followed by a disabled cycle carrying junk inputs
   task automatic en_tick(input logic d_in, input logic v_in, input logic [23:0] p_in);
      tick(1'b0, 1'b1, d_in, v_in, p_in);
      tick(1'b0, 1'b0, 1'($urandom), 1'($urandom), 24'($urandom));
   endtask

   initial begin
      bit vs_r;
      model_reset();
      tick(1'b1, 1'b1, 1'b0, 1'b0, 24'h0);
      tick(1'b1, 1'b1, 1'b0, 1'b0, 24'h0);
      chk("rst_luma", int'(luma_o), 0);
      chk("rst_cnt",  int'(cnt_o),  0);

      // luma latency and values
      tick(1'b0, 1'b1, 1'b1, 1'b0, 24'hFFFFFF);
      tick(1'b0, 1'b1, 1'b1, 1'b0, 24'h000000);
      chk("lat_early_luma", int'(luma_o), 0);
      tick(1'b0, 1'b1, 1'b1, 1'b0, 24'h808080);
      chk("white_luma",   int'(luma_o),   255);
      chk("white_bright", int'(bright_o), 1);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
      chk("black_luma",   int'(luma_o),   0);
      chk("black_bright", int'(bright_o), 0);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
      chk("grey_luma",    int'(luma_o),   128);
      chk("grey_bright",  int'(bright_o), 1);

      // arming, judging and threshold
      upd_seen = 0;
      send_frame(4, 1'b0);
      chk("arm_no_upd", upd_seen, 0);
      chk("arm_dark",   int'(dark_o), 0);
      send_frame(5, 1'b0);
      chk("b2_upd",  upd_seen, 1);
      chk("b2_cnt",  int'(cnt_o), 4);
      chk("b2_dark", int'(dark_o), 1);
      send_frame(2, 1'b0);
      chk("b3_cnt",  int'(cnt_o), 5);
      chk("b3_dark", int'(dark_o), 1);
      send_frame(0, 1'b0);
      chk("b4_cnt",  int'(cnt_o), 2);
      chk("b4_dark", int'(dark_o), 0);

      // saturation
      send_frame(12, 1'b0);
      send_frame(0, 1'b0);
      chk("sat_cnt",  int'(cnt_o), 7);
      chk("sat_dark", int'(dark_o), 1);

      // bright pixel on the boundary belongs to the new frame
      send_frame(3, 1'b0);
      send_frame(1, 1'b1);
      chk("coinc_excl", int'(cnt_o), 3);
      chk("coinc_dark", int'(dark_o), 0);
      send_frame(0, 1'b0);
      chk("coinc_incl", int'(cnt_o), 2);

      // reset mid-frame
      send_frame(5, 1'b0);
      send_frame(0, 1'b0);
      chk("pre_rst_dark", int'(dark_o), 1);
      tick(1'b0, 1'b1, 1'b1, 1'b0, 24'hFFFFFF);
      tick(1'b1, 1'b1, 1'b1, 1'b0, 24'hFFFFFF);
      chk("mid_rst_luma", int'(luma_o), 0);
      chk("mid_rst_dark", int'(dark_o), 0);
      chk("mid_rst_cnt",  int'(cnt_o),  0);
      upd_seen = 0;
      send_frame(5, 1'b0);
      chk("rearm_no_upd", upd_seen, 0);
      send_frame(0, 1'b0);
      chk("rearm_upd", upd_seen, 1);
      chk("rearm_cnt", int'(cnt_o), 5);

      // vs held active gives a single boundary
      upd_seen = 0;
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b1, 1'b1, 24'hFFFFFF);
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
      chk("held_vs_one_upd", upd_seen, 1);
      send_frame(0, 1'b0);
      chk("held_vs_cnt", int'(cnt_o), 6);

      // clock-enable decimation
      upd_seen = 0;
      en_tick(1'b0, 1'b1, 24'h0);
      for (int i = 0; i < 4; i++) en_tick(1'b1, 1'b0, 24'hFFFFFF);
      for (int i = 0; i < 3; i++) en_tick(1'b1, 1'b0, 24'h101010);
      en_tick(1'b0, 1'b1, 24'h0);
      for (int i = 0; i < 3; i++) en_tick(1'b0, 1'b0, 24'h0);
      chk("cen_upd",  upd_seen, 2);
      chk("cen_cnt",  int'(cnt_o), 4);
      chk("cen_dark", int'(dark_o), 1);

      // randomized run
      vs_r = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 15) == 0) vs_r = ~vs_r;
         tick(($urandom_range(0, 599) == 0), ($urandom_range(0, 3) != 0),
              1'($urandom), vs_r, 24'($urandom));
      end
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 9) == 0) vs_r = ~vs_r;
         tick(1'b0, 1'(i % 2 == 0), 1'($urandom), vs_r, 24'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
